// File: rtl/issue_unit_if.sv
// issue_unit_if: request/grant and CDB-ownership signals between the reservation stations and the issue unit
interface issue_unit_if;
  logic       flush;
  logic       int_issue_rdy;
  logic       mem_issue_rdy;
  logic       mult_issue_rdy;
  logic       div_issue_rdy;
  logic       mem_stall;
  logic       issue_done_int;
  logic       issue_done_mem;
  logic       issue_done_mult;
  logic       issue_done_div;
  logic       div_busy;
  logic       cdb_owner_valid;
  logic [1:0] cdb_owner;
  modport master (
    output flush, int_issue_rdy, mem_issue_rdy, mult_issue_rdy, div_issue_rdy, mem_stall,
    input  issue_done_int, issue_done_mem, issue_done_mult, issue_done_div,
    input  div_busy, cdb_owner_valid, cdb_owner
  );
  modport slave (
    input  flush, int_issue_rdy, mem_issue_rdy, mult_issue_rdy, div_issue_rdy, mem_stall,
    output issue_done_int, issue_done_mem, issue_done_mult, issue_done_div,
    output div_busy, cdb_owner_valid, cdb_owner
  );
endinterface

// File: rtl/issue_unit.sv
// issue_unit: grants reservation-station heads and books CDB slots ahead so results never collide.
// Entry k of the slot register means the CDB is owned k cycles from now.
module issue_unit #(
  parameter int INT_LAT  = 1,
  parameter int MEM_LAT  = 1,
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 7
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  issue_unit_if.slave  bus
);
  localparam int CW = $clog2(DIV_LAT);
  logic [DIV_LAT:0]       vld_q, vld_d;
  logic [DIV_LAT:0][1:0]  own_q, own_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   ptr_q, ptr_d;
  logic                   ok, e_int, e_mem, rr, g_int, g_mem, g_mult, g_div;
  always_comb begin
    ok     = i_rst_n & ~bus.flush;
    g_div  = ok & bus.div_issue_rdy & ~vld_q[DIV_LAT] & (cnt_q == '0);
    g_mult = ok & bus.mult_issue_rdy & ~vld_q[MULT_LAT] & ~(g_div & (MULT_LAT == DIV_LAT));
    e_int  = ok & bus.int_issue_rdy & ~vld_q[INT_LAT]
           & ~(g_div & (INT_LAT == DIV_LAT)) & ~(g_mult & (INT_LAT == MULT_LAT));
    e_mem  = ok & bus.mem_issue_rdy & ~bus.mem_stall & ~vld_q[MEM_LAT]
           & ~(g_div & (MEM_LAT == DIV_LAT)) & ~(g_mult & (MEM_LAT == MULT_LAT));
    // ptr_q low favours int; it flips only when the two actually contend for one slot
    rr     = e_int & e_mem & (INT_LAT == MEM_LAT);
    g_int  = e_int & ~(rr & ptr_q);
    g_mem  = e_mem & ~(rr & ~ptr_q);
    ptr_d  = rr ? ~ptr_q : ptr_q;
    vld_d  = {1'b0, vld_q[DIV_LAT:1]};
    own_d  = {2'b00, own_q[DIV_LAT:1]};
    if (g_int) begin
      vld_d[INT_LAT-1] = 1'b1;
      own_d[INT_LAT-1] = 2'd0;
    end
    if (g_mem) begin
      vld_d[MEM_LAT-1] = 1'b1;
      own_d[MEM_LAT-1] = 2'd1;
    end
    if (g_mult) begin
      vld_d[MULT_LAT-1] = 1'b1;
      own_d[MULT_LAT-1] = 2'd2;
    end
    if (g_div) begin
      vld_d[DIV_LAT-1] = 1'b1;
      own_d[DIV_LAT-1] = 2'd3;
    end
    cnt_d = g_div ? CW'(DIV_LAT - 1) : (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    if (bus.flush) begin
      vld_d = '0;
      own_d = '0;
      cnt_d = '0;
      ptr_d = 1'b0;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_q <= '0;
      own_q <= '0;
      cnt_q <= '0;
      ptr_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      own_q <= own_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
    end
  end
  assign bus.issue_done_int  = g_int;
  assign bus.issue_done_mem  = g_mem;
  assign bus.issue_done_mult = g_mult;
  assign bus.issue_done_div  = g_div;
  assign bus.div_busy        = |cnt_q;
  assign bus.cdb_owner_valid = vld_q[0];
  assign bus.cdb_owner       = own_q[0];
endmodule

// File: tb/tb_issue_unit.sv
// tb_issue_unit: directed test-plan scenarios plus random traffic, checked against an
// absolute-time CDB booking calendar model.
module tb_issue_unit;
  localparam int IL = 1, ML = 1, MUL = 4, DL = 7, N = 2048;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  issue_unit_if bus ();
  issue_unit #(.INT_LAT(IL), .MEM_LAT(ML), .MULT_LAT(MUL), .DIV_LAT(DL)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );
  int book [N];
  int cyc = 0, div_next = 0, compared = 0, mismatched = 0;
  bit ptr = 1'b0;
  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask
  task automatic step(input bit ri, input bit rm, input bit rmu, input bit rd, input bit st, input bit fl);
    bit gi, gm, gmu, gd, ei, em, ev;
    int eo;
    bus.int_issue_rdy  = ri;
    bus.mem_issue_rdy  = rm;
    bus.mult_issue_rdy = rmu;
    bus.div_issue_rdy  = rd;
    bus.mem_stall      = st;
    bus.flush          = fl;
    @(negedge clk);
    if (!rst_n) begin
      foreach (book[k]) book[k] = -1;
      div_next = 0;
      ptr = 1'b0;
    end
    ev = book[cyc] >= 0;
    eo = ev ? book[cyc] : 0;
    {gi, gm, gmu, gd} = 4'b0;
    if (rst_n && !fl) begin
      // grant in priority order, booking each slot immediately so lower priorities see it taken
      gd = rd && cyc >= div_next && book[cyc + DL] < 0;
      if (gd) begin book[cyc + DL] = 3; div_next = cyc + DL; end
      gmu = rmu && book[cyc + MUL] < 0;
      if (gmu) book[cyc + MUL] = 2;
      ei = ri && book[cyc + IL] < 0;
      em = rm && !st && book[cyc + ML] < 0;
      if (ei && em && IL == ML) begin
        gi = !ptr;
        gm = ptr;
        ptr = !ptr;
      end else begin
        gi = ei;
        gm = em;
      end
      if (gi) book[cyc + IL] = 0;
      if (gm) book[cyc + ML] = 1;
    end
    chk("done_int", {1'b0, bus.issue_done_int}, {1'b0, gi});
    chk("done_mem", {1'b0, bus.issue_done_mem}, {1'b0, gm});
    chk("done_mult", {1'b0, bus.issue_done_mult}, {1'b0, gmu});
    chk("done_div", {1'b0, bus.issue_done_div}, {1'b0, gd});
    chk("div_busy", {1'b0, bus.div_busy}, {1'b0, rst_n && cyc < div_next && !gd});
    chk("cdb_valid", {1'b0, bus.cdb_owner_valid}, {1'b0, ev});
    if (ev) chk("cdb_owner", bus.cdb_owner, 2'(eo));
    if (rst_n && fl) begin
      for (int k = cyc + 1; k <= cyc + DL; k++) book[k] = -1;
      div_next = cyc + 1;
      ptr = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    foreach (book[k]) book[k] = -1;
    // reset held with everything requesting, then a lone int request
    for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 0, 0);
    rst_n = 1'b1;
    step(1, 0, 0, 0, 0, 0);
    idle(2);
    // int/mem round robin, then mem stalled
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 1, 0);
    idle(2);
    // mult booking blocks int three cycles later
    step(0, 0, 1, 0, 0, 0);
    idle(2);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    idle(3);
    // divider occupancy with mult blocked by the div booking
    for (int i = 0; i < 9; i++) step(0, 0, i == 3 || i == 4, 1, 0, 0);
    idle(8);
    // flush discards mult and div bookings
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0);
    idle(9);
    // same-cycle int, mult and div
    step(1, 0, 1, 1, 0, 0);
    idle(8);
    // reset mid-operation
    step(1, 1, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    rst_n = 1'b0;
    step(1, 1, 1, 1, 0, 0);
    rst_n = 1'b1;
    idle(8);
    // random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(199) == 0) rst_n = 1'b0;
      step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(3) == 0, $urandom_range(15) == 0);
      rst_n = 1'b1;
    end
    idle(8);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/issue_unit.md
Name: issue_unit

Overview:
- Read side of the execution reservation stations: watches the head-ready flags of the int, mem, mult and div stations.
- Each cycle it decides which stations issue, and pulses the matching issue_done so the station pops its entry and the functional unit captures the data.
- It books the common data bus (CDB) in advance with a slot-reservation shift register, so no two results ever collide on the CDB.
- It reports which unit owns the CDB in each cycle.

Parameters:
INT_LAT, 1, cycles from int issue to result on CDB (>=1)
MEM_LAT, 1, cycles from mem issue to result on CDB (>=1)
MULT_LAT, 4, cycles from mult issue to result on CDB (pipelined unit)
DIV_LAT, 7, cycles from div issue to result on CDB (non-pipelined unit); must be the largest latency

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
flush  input  1  pipeline flush (branch mispredict / retire flush)
int_issue_rdy  input  1  int station head operands ready
mem_issue_rdy  input  1  ld/st station head ready
mult_issue_rdy  input  1  mult station head ready
div_issue_rdy  input  1  div station head ready
mem_stall  input  1  memory unit cannot accept (cache miss)
issue_done_int  output  1  grant/pop pulse to int station and int unit
issue_done_mem  output  1  grant/pop pulse to mem station and mem unit
issue_done_mult  output  1  grant/pop pulse to mult station and mult unit
issue_done_div  output  1  grant/pop pulse to div station and div unit
div_busy  output  1  divider occupied
cdb_owner_valid  output  1  a booked result drives CDB this cycle
cdb_owner  output  2  owner this cycle: 0 int, 1 mem, 2 mult, 3 div

Behaviour:
- Reset (async, i_rst_n low):
  - slot register cleared; div counter = 0; round-robin pointer = int.
  - all outputs 0 immediately.
- Slot register:
  - Entries k = 0..DIV_LAT, each holding {valid, owner[1:0]}.
  - Entry k means the CDB is booked k cycles from now.
  - cdb_owner_valid / cdb_owner are registered outputs driven from entry 0.
  - Each edge: entry k takes entry k+1 (top entry becomes empty), then each grant of latency L writes {1, id} into entry L-1.
- Grant rules (combinational, same cycle as rdy):
  - Unit X with latency L is eligible when all of the following hold:
    - X_issue_rdy is high;
    - entry L is free;
    - L does not collide with a higher-priority grant in the same cycle;
    - unit-specific conditions are met.
  - Unit-specific conditions: div requires div counter = 0; mem requires mem_stall = 0.
  - Priority among equal-latency eligible requests: div > mult > {int, mem}.
  - int vs mem is round robin. The pointer toggles only on a cycle where int and mem both request, the latencies collide, and one of them is granted; the winner is whichever the pointer selects, and the pointer then points to the other.
  - Different-latency requests are independent; up to 4 grants may occur per cycle.
  - issue_done_X = grant_X. The station pops and the FU captures data at that clock edge; no other handshake.
- Divider occupancy:
  - On a div grant, the counter loads DIV_LAT-1 and decrements each cycle down to 0.
  - div_busy = (counter != 0), registered.
  - The next div grant is possible at t+DIV_LAT at the earliest.
- Flush:
  - All issue_done forced 0 in the flush cycle.
  - At the edge: slot register cleared, div counter = 0, pointer = int.
  - cdb_owner_valid is 0 the cycle after flush.
- Boundaries:
  - rdy held with no free slot: the request waits with no pulse, and no state is disturbed.
  - A grant is never issued for a slot already booked, including entry L booked by a same-cycle higher-priority grant.
  - Reset mid-operation discards all bookings.
- Width:
  - Div counter is ceil(log2(DIV_LAT)) bits.
  - The slot register has DIV_LAT+1 entries.

Test Plan:
1. Reset: hold i_rst_n low with all rdy high -> all issue_done 0, div_busy 0, cdb_owner_valid 0. Release with int_issue_rdy high -> issue_done_int 1 in the first cycle; next cycle cdb_owner_valid 1, owner 0.
2. Round robin: int_issue_rdy and mem_issue_rdy held high for 4 cycles -> grants int, mem, int, mem; cdb_owner 0, 1, 0, 1 in the following cycles. Raising mem_stall mid-run -> int granted every cycle.
3. CDB conflict: mult granted at cycle 0, int_issue_rdy high from cycle 3 -> no int grant at cycle 3 (slot 4 booked); int granted at cycle 4. CDB owner mult at cycle 4, int at cycle 5.
4. Divider: div granted at cycle 0, div_issue_rdy held high -> div_busy 1 for cycles 1..6, next div grant at cycle 7. mult_issue_rdy at cycle 3 -> blocked (cycle 7 booked), granted at cycle 4.
5. Flush: mult granted at cycle 0, div at cycle 1, flush at cycle 2 with int_issue_rdy high -> issue_done_int 0 at cycle 2. cdb_owner_valid stays 0 at cycles 4 and 8. div_busy 0 from cycle 3; div grant possible at cycle 3.
6. Same-cycle multi-issue: int, mult and div all ready at cycle 0, all slots free -> all three issue_done high together. cdb_owner int at cycle 1, mult at cycle 4, div at cycle 7.
